card_dealer_ctrl: RTL and testbench

//   Shares the deck's random source between the player and dealer FSMs of the blackjack game.

---
 rtl/card_dealer_ctrl_pkg.sv | 15 +
 rtl/card_dealer_ctrl_lfsr16.sv | 22 ++
 rtl/card_dealer_ctrl.sv | 151 +++++++++++++++
 tb/tb_card_dealer_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/card_dealer_ctrl_pkg.sv
`timescale 1ns/1ps
// Shared constants, FSM state type and card point helper for the blackjack card dealer.
package dealer_pkg;

    localparam int         DECK_SIZE = 52;
    localparam logic [5:0] CARD_NONE = 6'h3F;

    typedef enum logic [1:0] {IDLE, DRAW, PROBE, GRANT} state_t;

    // Face cards count as ten; ace stays at one.
    function automatic logic [3:0] points(input logic [3:0] rank);
        return (rank > 4'd10) ? 4'd10 : rank;
    endfunction

endpackage

// File: rtl/card_dealer_ctrl_lfsr16.sv
`timescale 1ns/1ps
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded on reset.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        i_clock_50,
    input  logic        i_resetn,
    output logic [15:0] o_q
);

    logic [15:0] r_q;
    logic        w_fb;

    assign w_fb = r_q[15] ^ r_q[13] ^ r_q[12] ^ r_q[10];
    assign o_q  = r_q;

    always_ff @(posedge i_clock_50) begin
        if (!i_resetn) r_q <= SEED;
        else           r_q <= {r_q[14:0], w_fb};
    end

endmodule

// File: rtl/card_dealer_ctrl.sv
`timescale 1ns/1ps
// Arbitrates player/dealer draw requests and deals unique cards from one deck.
//   state | meaning
//   IDLE  | apply pending shuffle, else arbitrate requests
//   DRAW  | fold LFSR sample into a card index
//   PROBE | step past dealt cards, claim the first free one
//   GRANT | one-cycle ack to the winner
module card_dealer_ctrl
    import dealer_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       i_clock_50,
    input  logic       i_resetn,
    input  logic [1:0] i_req,
    input  logic       i_shuffle,
    output logic [1:0] o_ack,
    output logic [5:0] o_card_idx,
    output logic [3:0] o_card_rank,
    output logic [3:0] o_card_pts,
    output logic       o_deck_empty,
    output logic [5:0] o_cards_left,
    output logic       o_busy
);

    localparam logic [5:0] DECK_CNT = 6'(DECK_SIZE);
    localparam logic [5:0] LAST_IDX = 6'(DECK_SIZE - 1);

    logic [15:0] w_lfsr;
    logic [9:0]  w_unused_lfsr;
    logic [5:0]  w_rnd;
    logic [5:0]  w_draw_idx;
    logic [5:0]  w_next_idx;
    logic [3:0]  w_rank0;
    logic        w_winner;

    state_t      r_state;
    logic [51:0] r_used;
    logic [5:0]  r_idx;
    logic        r_win;
    logic        r_rr;
    logic        r_shuffle_pend;
    logic [5:0]  r_cards_left;
    logic [1:0]  r_ack;
    logic [5:0]  r_card_idx;
    logic [3:0]  r_card_rank;
    logic [3:0]  r_card_pts;
    logic        r_deck_empty;
    logic        r_busy;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .i_clock_50 (i_clock_50),
        .i_resetn   (i_resetn),
        .o_q        (w_lfsr)
    );

    assign w_rnd         = w_lfsr[5:0];
    assign w_unused_lfsr = w_lfsr[15:6];
    assign w_draw_idx    = (w_rnd >= DECK_CNT) ? w_rnd - DECK_CNT : w_rnd;
    assign w_next_idx    = (r_idx == LAST_IDX) ? 6'd0 : r_idx + 6'd1;
    assign w_winner      = (i_req[0] & i_req[1]) ? r_rr : i_req[1];

    // idx mod 13 without a divider: at most three suit offsets to remove.
    always_comb begin
        if (r_idx >= 6'd39)      w_rank0 = 4'(r_idx - 6'd39);
        else if (r_idx >= 6'd26) w_rank0 = 4'(r_idx - 6'd26);
        else if (r_idx >= 6'd13) w_rank0 = 4'(r_idx - 6'd13);
        else                     w_rank0 = r_idx[3:0];
    end

    always_ff @(posedge i_clock_50) begin
        if (!i_resetn) begin
            r_state        <= IDLE;
            r_used         <= '0;
            r_idx          <= '0;
            r_win          <= 1'b0;
            r_rr           <= 1'b0;
            r_shuffle_pend <= 1'b0;
            r_cards_left   <= DECK_CNT;
            r_ack          <= 2'b00;
            r_card_idx     <= '0;
            r_card_rank    <= '0;
            r_card_pts     <= '0;
            r_deck_empty   <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_ack <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (r_shuffle_pend) begin
                        r_used         <= '0;
                        r_cards_left   <= DECK_CNT;
                        r_shuffle_pend <= 1'b0;
                    end else if (|i_req) begin
                        r_win  <= w_winner;
                        r_busy <= 1'b1;
                        if (r_cards_left == 6'd0) begin
                            r_state      <= GRANT;
                            r_ack        <= w_winner ? 2'b10 : 2'b01;
                            r_rr         <= ~w_winner;
                            r_card_idx   <= CARD_NONE;
                            r_card_rank  <= 4'd0;
                            r_card_pts   <= 4'd0;
                            r_deck_empty <= 1'b1;
                        end else begin
                            r_state <= DRAW;
                        end
                    end
                end
                DRAW: begin
                    r_idx   <= w_draw_idx;
                    r_state <= PROBE;
                end
                PROBE: begin
                    if (r_used[r_idx]) begin
                        r_idx <= w_next_idx;
                    end else begin
                        r_used[r_idx] <= 1'b1;
                        r_cards_left  <= r_cards_left - 6'd1;
                        r_ack         <= r_win ? 2'b10 : 2'b01;
                        r_rr          <= ~r_win;
                        r_card_idx    <= r_idx;
                        r_card_rank   <= w_rank0 + 4'd1;
                        r_card_pts    <= points(w_rank0 + 4'd1);
                        r_deck_empty  <= 1'b0;
                        r_state       <= GRANT;
                    end
                end
                GRANT: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
            // A pulse arriving while a shuffle is being applied re-arms it.
            if (i_shuffle) r_shuffle_pend <= 1'b1;
        end
    end

    assign o_ack        = r_ack;
    assign o_card_idx   = r_card_idx;
    assign o_card_rank  = r_card_rank;
    assign o_card_pts   = r_card_pts;
    assign o_deck_empty = r_deck_empty;
    assign o_cards_left = r_cards_left;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_card_dealer_ctrl.sv
`timescale 1ns/1ps
// Directed bench for card_dealer_ctrl: dealing, uniqueness, empty deck, round robin, shuffle, reset abort.
module tb_card_dealer_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] req;
    logic       shuffle;
    logic [1:0] ack;
    logic [5:0] card_idx;
    logic [3:0] card_rank;
    logic [3:0] card_pts;
    logic       deck_empty;
    logic [5:0] cards_left;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [5:0] b_idx;
    int         lat;
    int         missing;
    bit         seen [52];
    int         np, nd, cyc;
    bit         got;
    logic [1:0] seq [4];

    always #10 clk = ~clk;

    card_dealer_ctrl #(.LFSR_SEED(16'hACE1)) dut (
        .i_clock_50   (clk),
        .i_resetn     (resetn),
        .i_req        (req),
        .i_shuffle    (shuffle),
        .o_ack        (ack),
        .o_card_idx   (card_idx),
        .o_card_rank  (card_rank),
        .o_card_pts   (card_pts),
        .o_deck_empty (deck_empty),
        .o_cards_left (cards_left),
        .o_busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_rank(input int idx);
        return (idx % 13) + 1;
    endfunction

    function automatic int exp_pts(input int idx);
        return (exp_rank(idx) > 10) ? 10 : exp_rank(idx);
    endfunction

    task automatic check_reset_state(input string pfx);
        chk({pfx, "_ack"},        ack,        0);
        chk({pfx, "_card_idx"},   card_idx,   0);
        chk({pfx, "_card_rank"},  card_rank,  0);
        chk({pfx, "_card_pts"},   card_pts,   0);
        chk({pfx, "_deck_empty"}, deck_empty, 0);
        chk({pfx, "_cards_left"}, cards_left, 52);
        chk({pfx, "_busy"},       busy,       0);
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge of the following IDLE cycle.
    task automatic draw(input int who, input bit shuf, input bit exp_empty,
                        output logic [5:0] idx, output int l);
        logic [1:0] oh;
        bit         seen_ack;
        oh       = (who == 1) ? 2'b10 : 2'b01;
        seen_ack = 1'b0;
        l        = 0;
        idx      = '0;
        req      = req | oh;
        while (!seen_ack && l < 60) begin
            @(posedge clk);
            @(negedge clk);
            l++;
            shuffle = shuf && (l == 1);
            if (ack != 2'b00) seen_ack = 1'b1;
        end
        shuffle = 1'b0;
        req     = req & ~oh;
        chk("ack_seen", seen_ack, 1);
        if (seen_ack) begin
            chk("ack_dest", ack, oh);
            chk("deck_empty_flag", deck_empty, exp_empty);
            chk("latency_max", l <= 54, 1);
            idx = card_idx;
            if (exp_empty) begin
                chk("empty_idx",  card_idx,  6'h3F);
                chk("empty_rank", card_rank, 0);
                chk("empty_pts",  card_pts,  0);
            end else begin
                chk("idx_range", card_idx < 6'd52, 1);
                chk("card_rank", card_rank, exp_rank(int'(card_idx)));
                chk("card_pts",  card_pts,  exp_pts(int'(card_idx)));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn  = 1'b0;
        req     = 2'b00;
        shuffle = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("rst");

        // First draw from the seeded LFSR: sample 0x59C3 -> rnd 3.
        resetn = 1'b1;
        draw(0, 1'b0, 1'b0, b_idx, lat);
        chk("t1_latency", lat, 3);
        chk("t1_idx", b_idx, 3);
        chk("t1_rank", card_rank, 4);
        chk("t1_pts", card_pts, 4);
        chk("t1_left", cards_left, 51);
        foreach (seen[k]) seen[k] = 1'b0;
        seen[b_idx] = 1'b1;

        for (int n = 1; n < 52; n++) begin
            if (n == 51) begin
                missing = -1;
                for (int k = 0; k < 52; k++) if (!seen[k]) missing = k;
            end
            draw(n % 2, 1'b0, 1'b0, b_idx, lat);
            if (b_idx < 6'd52) begin
                chk("unique", seen[b_idx], 0);
                seen[b_idx] = 1'b1;
            end
            chk("left", cards_left, 51 - n);
            if (n == 51) chk("last_card", b_idx, missing);
        end

        draw(0, 1'b0, 1'b1, b_idx, lat);
        chk("empty_latency", lat, 1);
        chk("empty_left", cards_left, 0);

        // Round robin with both requests held.
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        req    = 2'b11;
        seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
        np = 0;
        nd = 0;
        for (int g = 0; g < 4; g++) begin
            got = 1'b0;
            cyc = 0;
            while (!got && cyc < 60) begin
                @(posedge clk);
                @(negedge clk);
                cyc++;
                if (ack != 2'b00) got = 1'b1;
            end
            chk("rr_seen", got, 1);
            chk("rr_order", ack, seq[g]);
            if (ack == 2'b01) np++;
            if (ack == 2'b10) nd++;
            if (g == 0) chk("rr_first_idx", card_idx, 3);
        end
        req = 2'b00;
        chk("rr_player_cnt", np, 2);
        chk("rr_dealer_cnt", nd, 2);
        chk("rr_left", cards_left, 48);
        @(posedge clk);
        @(negedge clk);

        // Ten dealt, then a shuffle lands during the eleventh draw.
        for (int n = 0; n < 6; n++) draw(n % 2, 1'b0, 1'b0, b_idx, lat);
        chk("t4_left", cards_left, 42);
        draw(0, 1'b1, 1'b0, b_idx, lat);
        chk("shuf_draw_left", cards_left, 41);
        chk("shuf_idle_busy", busy, 0);
        chk("shuf_pending_left", cards_left, 41);
        @(posedge clk);
        @(negedge clk);
        chk("shuf_applied_left", cards_left, 52);

        // Reset during PROBE aborts the draw; coincident shuffle is dropped.
        req = 2'b01;
        @(posedge clk);
        @(negedge clk);
        chk("t6_busy", busy, 1);
        @(posedge clk);
        @(negedge clk);
        chk("t6_no_ack", ack, 0);
        resetn  = 1'b0;
        shuffle = 1'b1;
        @(posedge clk);
        @(negedge clk);
        shuffle = 1'b0;
        check_reset_state("t6");
        resetn = 1'b1;
        draw(0, 1'b0, 1'b0, b_idx, lat);
        chk("t6_latency", lat, 3);
        chk("t6_idx", b_idx, 3);
        chk("t6_rank", card_rank, 4);
        chk("t6_pts", card_pts, 4);
        chk("t6_left", cards_left, 51);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
